// File: rtl/tia_horizontal_sync_counter.sv
// TIA horizontal sequencer: divides the color clock by 4 into two-phase
// horizontal clocks, runs the 57-state line counter, and decodes the blank,
// sync and burst strobes. RSYNC realigns the counter at the next phase
// boundary without disturbing the phase clocks.
module tia_horizontal_sync_counter #(
  parameter int LINE_COUNTS = 57,
  parameter int SHB_COUNT   = 0,
  parameter int SHS_COUNT   = 4,
  parameter int RHS_COUNT   = 8,
  parameter int RCB_COUNT   = 12,
  parameter int RHB_COUNT   = 16,
  parameter int LRHB_COUNT  = 18,
  parameter int CNT_COUNT   = 36
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       rsync,
  output logic       hphi1,
  output logic       hphi2,
  output logic       shb,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       lrhb,
  output logic       cnt,
  output logic       rsynd,
  output logic       line_start,
  output logic [5:0] hcount
);

  localparam logic [5:0] LAST = 6'(LINE_COUNTS - 1);

  logic [1:0] phase_q, phase_d;
  logic [5:0] hcount_q, hcount_d;
  logic       pend_q, pend_d;
  logic       ls_q, ls_d;
  logic       boundary;

  // Next state: phase free-runs; hcount and the RSYNC latch only move on 3->0.
  always_comb begin
    boundary = (phase_q == 2'd3);
    phase_d  = phase_q + 2'd1;
    hcount_d = hcount_q;
    pend_d   = pend_q | rsync;
    ls_d     = 1'b0;
    if (boundary) begin
      // Illegal values (>= LINE_COUNTS) fall into the wrap case as well.
      if (hcount_q >= LAST || pend_q) hcount_d = 6'd0;
      else                            hcount_d = hcount_q + 6'd1;
      ls_d   = (hcount_d == 6'd0);
      // An RSYNC landing on the boundary edge is held for the next boundary.
      pend_d = rsync;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      phase_q  <= 2'd0;
      hcount_q <= LAST;
      pend_q   <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hcount_q <= hcount_d;
      pend_q   <= pend_d;
      ls_q     <= ls_d;
    end
  end

  // Output decodes straight off the registers; rsync never reaches an output combinationally.
  always_comb begin
    hphi1      = (phase_q == 2'd1);
    hphi2      = (phase_q == 2'd3);
    shb        = (hcount_q == 6'(SHB_COUNT));
    shs        = (hcount_q == 6'(SHS_COUNT));
    rhs        = (hcount_q == 6'(RHS_COUNT));
    rcb        = (hcount_q == 6'(RCB_COUNT));
    rhb        = (hcount_q == 6'(RHB_COUNT));
    lrhb       = (hcount_q == 6'(LRHB_COUNT));
    cnt        = (hcount_q == 6'(CNT_COUNT));
    rsynd      = pend_q;
    line_start = ls_q;
    hcount     = hcount_q;
  end

endmodule

// File: tb/tb_tia_horizontal_sync_counter.sv
// Directed bench for the TIA horizontal sequencer: reset timing, free-running
// lines, RSYNC mid-line / on boundary / repeated / at wrap, async reset.
module tb_tia_horizontal_sync_counter;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       rsync;
  logic       hphi1, hphi2, shb, shs, rhs, rcb, rhb, lrhb, cnt, rsynd, line_start;
  logic [5:0] hcount;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tia_horizontal_sync_counter dut (
    .clk(clk), .reset_bar(reset_bar), .rsync(rsync),
    .hphi1(hphi1), .hphi2(hphi2), .shb(shb), .shs(shs), .rhs(rhs),
    .rcb(rcb), .rhb(rhb), .lrhb(lrhb), .cnt(cnt), .rsynd(rsynd),
    .line_start(line_start), .hcount(hcount)
  );

  always #5 clk = ~clk;

  logic [10:0] outs;
  assign outs = {hphi1, hphi2, shb, shs, rhs, rcb, rhb, lrhb, cnt, rsynd, line_start};

  logic [6:0] strb;
  assign strb = {shb, shs, rhs, rcb, rhb, lrhb, cnt};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Lands on the first clk of hcount==v (phase 0).
  task automatic wait_hc(input int v, input string tag);
    int n;
    n = 0;
    while (hcount == 6'(v) && n < 300) begin tick(); n++; end
    while (hcount != 6'(v) && n < 300) begin tick(); n++; end
    if (n >= 300) chk({tag, "_timeout"}, 32'(hcount), 32'(v));
  endtask

  // Ticks until line_start; returns clks elapsed (or 999 on timeout).
  task automatic wait_ls(output int len);
    int n;
    n = 0;
    do begin tick(); n++; end while (!line_start && n < 300);
    len = line_start ? n : 999;
  endtask

  task automatic post_reset(input string p);
    tick();
    chk({p, "_e1_hphi1"}, 32'(hphi1), 1);
    chk({p, "_e1_hphi2"}, 32'(hphi2), 0);
    tick();
    chk({p, "_e2_phi"}, 32'({hphi1, hphi2}), 0);
    tick();
    chk({p, "_e3_hphi2"}, 32'({hphi1, hphi2}), 1);
    chk({p, "_e3_hcount"}, 32'(hcount), 56);
    tick();
    chk({p, "_e4_hcount"}, 32'(hcount), 0);
    chk({p, "_e4_shb"}, 32'(shb), 1);
    chk({p, "_e4_ls"}, 32'(line_start), 1);
  endtask

  int exp_hc [7] = '{0, 4, 8, 12, 16, 18, 36};
  int scnt [7];
  int sbad, p1, p2, both, hmax, last_ls, len;

  initial begin
    reset_bar = 1'b0;
    rsync     = 1'b0;
    #12;
    chk("rst_outs", 32'(outs), 0);
    chk("rst_hcount", 32'(hcount), 56);
    @(negedge clk);
    reset_bar = 1'b1;
    post_reset("rel");

    // Free run: three full lines.
    foreach (scnt[i]) scnt[i] = 0;
    sbad = 0; p1 = 0; p2 = 0; both = 0; hmax = 0; last_ls = cyc;
    for (int k = 0; k < 3 * 228; k++) begin
      tick();
      if (line_start) begin
        chk("line_period", 32'(cyc - last_ls), 228);
        last_ls = cyc;
      end
      for (int i = 0; i < 7; i++)
        if (strb[6 - i]) begin
          scnt[i]++;
          if (int'(hcount) != exp_hc[i]) sbad++;
        end
      if (hphi1) p1++;
      if (hphi2) p2++;
      if (hphi1 && hphi2) both++;
      if (int'(hcount) > hmax) hmax = int'(hcount);
    end
    for (int i = 0; i < 7; i++) chk($sformatf("strobe%0d_clks", i), 32'(scnt[i]), 12);
    chk("strobe_pos", 32'(sbad), 0);
    chk("hphi1_count", 32'(p1), 171);
    chk("hphi2_count", 32'(p2), 171);
    chk("hphi_overlap", 32'(both), 0);
    chk("hcount_max", 32'(hmax), 56);

    // RSYNC mid-line, captured on the edge into phase 1 of hcount 20.
    wait_hc(20, "mid");
    rsync = 1'b1; tick(); rsync = 1'b0;
    chk("mid_rsynd1", 32'(rsynd), 1);
    chk("mid_hc", 32'(hcount), 20);
    tick(); chk("mid_rsynd2", 32'(rsynd), 1);
    tick(); chk("mid_rsynd3", 32'(rsynd), 1);
    tick();
    chk("mid_hc0", 32'(hcount), 0);
    chk("mid_shb", 32'(shb), 1);
    chk("mid_ls", 32'(line_start), 1);
    chk("mid_rsynd_clr", 32'(rsynd), 0);
    wait_ls(len);
    chk("mid_next_line", 32'(len), 228);

    // RSYNC on the boundary edge 30->31.
    wait_hc(30, "bnd");
    tick(); tick(); tick();
    rsync = 1'b1; tick(); rsync = 1'b0;
    chk("bnd_hc31_0", 32'(hcount), 31);
    chk("bnd_rsynd_0", 32'(rsynd), 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("bnd_hc31_%0d", k), 32'(hcount), 31);
      chk($sformatf("bnd_rsynd_%0d", k), 32'(rsynd), 1);
    end
    tick();
    chk("bnd_hc0", 32'(hcount), 0);
    chk("bnd_ls", 32'(line_start), 1);
    chk("bnd_rsynd_clr", 32'(rsynd), 0);

    // Two RSYNC pulses two clks apart: one realignment.
    wait_hc(10, "dbl");
    rsync = 1'b1; tick(); rsync = 1'b0;
    tick();
    rsync = 1'b1; tick(); rsync = 1'b0;
    chk("dbl_rsynd", 32'(rsynd), 1);
    tick();
    chk("dbl_hc0", 32'(hcount), 0);
    chk("dbl_ls", 32'(line_start), 1);
    chk("dbl_rsynd_clr", 32'(rsynd), 0);
    wait_ls(len);
    chk("dbl_next_line", 32'(len), 228);

    // RSYNC at hcount 56: ordinary wrap, no short line.
    wait_hc(56, "wrap");
    rsync = 1'b1; tick(); rsync = 1'b0;
    tick(); tick(); tick();
    chk("wrap_hc0", 32'(hcount), 0);
    chk("wrap_ls", 32'(line_start), 1);
    chk("wrap_rsynd_clr", 32'(rsynd), 0);
    wait_ls(len);
    chk("wrap_next_line", 32'(len), 228);

    // Asynchronous reset at hcount 40, phase 2.
    wait_hc(40, "arst");
    tick(); tick();
    chk("arst_pre_hc", 32'(hcount), 40);
    #2 reset_bar = 1'b0;
    #1;
    chk("arst_outs", 32'(outs), 0);
    chk("arst_hcount", 32'(hcount), 56);
    @(negedge clk);
    @(negedge clk);
    reset_bar = 1'b1;
    post_reset("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tia_horizontal_sync_counter.md
Name: tia_horizontal_sync_counter

Overview:
- Horizontal sequencer that drives the TIA horizontal timing block.
- Divides the color clock by 4 to produce the two-phase horizontal clocks `hphi1` and `hphi2`.
- Runs a 57-state horizontal counter (57 × 4 = 228 color clocks per line).
- Emits one-count-wide decode strobes (`shb`, `shs`, `rhs`, `rcb`, `rhb`, `lrhb`, `cnt`) that set and reset the blank, sync and color-burst latches downstream.
- Handles the RSYNC strobe, which realigns the counter to line start.

Parameters:
- LINE_COUNTS, 57, counter states per line; hcount wraps from LINE_COUNTS-1 to 0.
- SHB_COUNT, 0, hcount at which shb asserts (start horizontal blank).
- SHS_COUNT, 4, hcount at which shs asserts (set horizontal sync).
- RHS_COUNT, 8, hcount at which rhs asserts (reset horizontal sync).
- RCB_COUNT, 12, hcount at which rcb asserts (reset color burst).
- RHB_COUNT, 16, hcount at which rhb asserts (reset horizontal blank).
- LRHB_COUNT, 18, hcount at which lrhb asserts (late reset of horizontal blank, HMOVE lines).
- CNT_COUNT, 36, hcount at which cnt asserts (line center).

Ports:
- clk  input  1  color clock; all state updates on the rising edge.
- reset_bar  input  1  asynchronous, active-low reset.
- rsync  input  1  synchronous one-clk RSYNC strobe from the register-write decode.
- hphi1  output  1  horizontal phase 1; high while phase==1.
- hphi2  output  1  horizontal phase 2; high while phase==3.
- shb  output  1  high while hcount==SHB_COUNT.
- shs  output  1  high while hcount==SHS_COUNT.
- rhs  output  1  high while hcount==RHS_COUNT.
- rcb  output  1  high while hcount==RCB_COUNT.
- rhb  output  1  high while hcount==RHB_COUNT.
- lrhb  output  1  high while hcount==LRHB_COUNT.
- cnt  output  1  high while hcount==CNT_COUNT.
- rsynd  output  1  RSYNC pending; high from the clk after rsync until the realignment boundary.
- line_start  output  1  one-clk pulse on the clk in which hcount becomes 0.
- hcount  output  6  current counter value, 0..56, for debug and visibility.

Behaviour:
- State is `phase[1:0]`, `hcount[5:0]` and `rsync_pend`. All outputs come directly from flops or from decodes of flops loaded on the same edge; no combinational path from rsync to any output.
- Reset (reset_bar low, asynchronous):
  - phase=0, hcount=LINE_COUNTS-1 (56), rsync_pend=0.
  - hphi1, hphi2, all decode strobes, rsynd and line_start are 0.
  - Outputs hold while reset_bar is low.
- Phase: increments every clk, modulo 4.
  - hphi1 is high exactly when phase==1.
  - hphi2 is high exactly when phase==3.
  - The two phases are never high together, with one clk gap either side of each.
- Boundary: the edge where phase goes 3→0.
  - hcount next = 0 if hcount==LINE_COUNTS-1 or rsync_pend==1; otherwise hcount+1.
  - line_start=1 for that single clk whenever hcount next == 0, and 0 otherwise.
- Decode strobes: each is high for exactly the 4 clks during which hcount equals its parameter, so one strobe per line.
  - Strobes never overlap, given distinct parameter values.
- RSYNC:
  - rsync high at an edge sets rsync_pend; rsynd mirrors rsync_pend.
  - At the next boundary, hcount loads 0, rsync_pend clears and shb asserts.
  - phase is not reset, so hphi alignment is preserved.
  - Further rsync while already pending: no additional effect.
- Simultaneous rsync and boundary on the same edge: rsync is captured, and realignment happens at the following boundary (4 clks later).
- Natural wrap while rsync is pending: hcount loads 0 either way, and rsync_pend clears.
- Reset mid-line: returns immediately to the reset state. The first post-reset boundary (4th edge) yields hcount=0.
- hcount never exceeds LINE_COUNTS-1. Any illegal value (≥ LINE_COUNTS) loads 0 at the next boundary.

Test Plan:
- Reset values: hold reset_bar low, release.
  - During reset: all outputs 0 and hcount=56.
  - Edge 1: hphi1=1.
  - Edge 3: hphi2=1.
  - Edge 4: hcount=0, shb=1 and line_start=1.
- Free run for 3 lines.
  - line_start period is 228 clks.
  - hphi1 and hphi2 each have period 4 and are never both high.
  - Each strobe (shb, shs, rhs, rcb, rhb, lrhb, cnt) is high for exactly 4 clks per line, at hcount 0/4/8/12/16/18/36 respectively.
- RSYNC mid-line: pulse rsync while hcount=20, phase=1.
  - rsynd=1 for 3 clks.
  - At the boundary: hcount=0 (not 21), shb=1, line_start=1, rsynd=0.
  - The following line is 228 clks long.
- RSYNC on the boundary edge: pulse rsync on the edge where hcount goes 30→31.
  - hcount=31 for 4 clks, then 0.
  - rsynd is high for 4 clks.
- RSYNC while pending, and at wrap:
  - Two rsync pulses 2 clks apart produce a single realignment.
  - rsync at hcount=56 gives a normal wrap to 0 with no extra short line.
- Asynchronous reset at hcount=40, phase=2:
  - All outputs 0 immediately, without waiting for a clk edge.
  - After release, timing matches the reset-values scenario.
